// File: rtl/microcore_scheduler_if.sv
// Work-in / result-out bundle between the microcore scheduler and its host logic.
// NONCE_RANGE_EN adds the per-work nonce start/end fields.
interface microcore_scheduler_if #(
   parameter int CORES = 1
);
`ifdef NONCE_RANGE_EN
   logic [31:0]      work_nonce_start;
   logic [31:0]      work_nonce_end;
`endif
   logic             new_work;
   logic [255:0]     work_midstate;
   logic [95:0]      work_data;
   logic [CORES-1:0] gnon;
   logic             tx_busy;
   logic [7:0]       cnt;
   logic             pass;
   logic [255:0]     midstate;
   logic [95:0]      data;
   logic [31:0]      nonce;
   logic             tx_send;
   logic [31:0]      tx_word;
   logic             fifo_overflow;

   modport master (
`ifdef NONCE_RANGE_EN
      output work_nonce_start, work_nonce_end,
`endif
      output new_work, work_midstate, work_data, gnon, tx_busy,
      input  cnt, pass, midstate, data, nonce, tx_send, tx_word, fifo_overflow
   );

   modport slave (
`ifdef NONCE_RANGE_EN
      input  work_nonce_start, work_nonce_end,
`endif
      input  new_work, work_midstate, work_data, gnon, tx_busy,
      output cnt, pass, midstate, data, nonce, tx_send, tx_word, fifo_overflow
   );
endinterface

// File: rtl/microcore_scheduler.sv
// Round sequencer and golden-nonce collector for CORES microcore hashers.
// Optional macro NONCE_RANGE_EN: per-work nonce start/end bounds.
module microcore_scheduler #(
   parameter int CORES      = 1,
   parameter int FIFO_DEPTH = 4,
   parameter int P0_LAST    = 66,
   parameter int P1_LAST    = 61,
   parameter int CHECK_CNT  = 1
) (
   input logic                  hash_clk,
   input logic                  reset,
   microcore_scheduler_if.slave bus
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [7:0]  P0_LAST_C   = 8'(P0_LAST);
   localparam logic [7:0]  P1_LAST_C   = 8'(P1_LAST);
   localparam logic [7:0]  CHECK_C     = 8'(CHECK_CNT);
   localparam logic [7:0]  MARKER_C    = 8'(CHECK_CNT + 1);
   localparam logic [AW:0] DEPTH_C     = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] CNT_ZERO_C  = (AW+1)'(0);
   localparam logic [AW:0] CNT_ONE_C   = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE_C = AW'(1);

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_SEND  = 2'd1,
      TX_GUARD = 2'd2
   } tx_state_e;

   logic [7:0]    cnt_q, cnt_d;
   logic          pass_q, pass_d;
   logic [31:0]   nonce_q, nonce_d;
   logic [255:0]  midstate_q, midstate_d, pend_mid_q, pend_mid_d;
   logic [95:0]   data_q, data_d, pend_data_q, pend_data_d;
   logic          pending_q, pending_d;
   logic          exhausted_q, exhausted_d;
   logic          suppress_q, suppress_d;
   logic          marker_q, marker_d;
   logic          overflow_q, overflow_d;
   logic [31:0]   fifo_mem_q [FIFO_DEPTH];
   logic [31:0]   fifo_mem_d [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   tx_state_e     tx_state_q;
   logic          tx_send_q;
   logic [31:0]   tx_word_q;

   logic          boundary_s, swap_s, check_s, marker_slot_s, exhaust_s;
   logic          push_s, wr_ok_s, pop_s, full_s;
   logic [31:0]   push_word_s;
   logic [32:0]   sum_s;
   logic [31:0]   start_s, end_s, swap_start_s;

   function automatic logic [31:0] lowest_set(input logic [CORES-1:0] v);
      logic [31:0] idx;
      idx = 32'd0;
      for (int j = CORES - 1; j >= 0; j--) begin
         if (v[j]) begin
            idx = 32'(j);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   assign boundary_s    = pass_q && (cnt_q == P1_LAST_C);
   assign swap_s        = boundary_s && (bus.new_work || pending_q);
   assign check_s       = !pass_q && (cnt_q == CHECK_C);
   assign marker_slot_s = !pass_q && (cnt_q == MARKER_C);
   assign sum_s         = {1'b0, nonce_q} + 33'(CORES);
   // A 33-bit compare covers both the carry-out and the configured end limit.
   assign exhaust_s     = sum_s > {1'b0, end_s};
   assign full_s        = (count_q == DEPTH_C);
   assign pop_s         = (tx_state_q == TX_IDLE) && (count_q != CNT_ZERO_C) && !bus.tx_busy;

`ifdef NONCE_RANGE_EN
   logic [31:0] start_q, start_d, end_q, end_d;
   logic [31:0] pend_start_q, pend_start_d, pend_end_q, pend_end_d;

   assign start_s      = start_q;
   assign end_s        = end_q;
   assign swap_start_s = bus.new_work ? bus.work_nonce_start : pend_start_q;

   // Next-state logic for the active and pending nonce range.
   always_comb begin
      start_d      = start_q;
      end_d        = end_q;
      pend_start_d = pend_start_q;
      pend_end_d   = pend_end_q;
      if (boundary_s && bus.new_work) begin
         start_d = bus.work_nonce_start;
         end_d   = bus.work_nonce_end;
      end else if (boundary_s && pending_q) begin
         start_d = pend_start_q;
         end_d   = pend_end_q;
      end else if (bus.new_work) begin
         pend_start_d = bus.work_nonce_start;
         pend_end_d   = bus.work_nonce_end;
      end else begin
         start_d = start_q;
      end
   end

   // Nonce range registers.
   always_ff @(posedge hash_clk or posedge reset) begin
      if (reset) begin
         start_q      <= 32'h0000_0000;
         end_q        <= 32'hFFFF_FFFF;
         pend_start_q <= 32'h0000_0000;
         pend_end_q   <= 32'hFFFF_FFFF;
      end else begin
         start_q      <= start_d;
         end_q        <= end_d;
         pend_start_q <= pend_start_d;
         pend_end_q   <= pend_end_d;
      end
   end
`else
   assign start_s      = 32'h0000_0000;
   assign end_s        = 32'hFFFF_FFFF;
   assign swap_start_s = 32'h0000_0000;
`endif

   // Next-state logic for sequencing, work buffers, result flags and the FIFO.
   always_comb begin
      cnt_d       = cnt_q;
      pass_d      = pass_q;
      nonce_d     = nonce_q;
      midstate_d  = midstate_q;
      data_d      = data_q;
      pend_mid_d  = pend_mid_q;
      pend_data_d = pend_data_q;
      pending_d   = pending_q;
      exhausted_d = exhausted_q;
      suppress_d  = suppress_q;
      marker_d    = marker_q;
      overflow_d  = overflow_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      fifo_mem_d  = fifo_mem_q;
      push_s      = 1'b0;
      push_word_s = 32'h0000_0000;
      wr_ok_s     = 1'b0;

      if (!pass_q && (cnt_q == P0_LAST_C)) begin
         cnt_d  = 8'd0;
         pass_d = 1'b1;
      end else if (boundary_s) begin
         cnt_d  = 8'd0;
         pass_d = 1'b0;
      end else begin
         cnt_d = cnt_q + 8'd1;
      end

      if (boundary_s) begin
         if (bus.new_work) begin
            midstate_d = bus.work_midstate;
            data_d     = bus.work_data;
         end else if (pending_q) begin
            midstate_d = pend_mid_q;
            data_d     = pend_data_q;
         end else begin
            midstate_d = midstate_q;
         end
         if (swap_s) begin
            nonce_d     = swap_start_s;
            pending_d   = 1'b0;
            exhausted_d = 1'b0;
            suppress_d  = 1'b1;
            marker_d    = 1'b0;
            overflow_d  = 1'b0;
         end else if (exhaust_s) begin
            nonce_d     = start_s;
            exhausted_d = 1'b1;
            marker_d    = marker_q | ~exhausted_q;
         end else begin
            nonce_d = sum_s[31:0];
         end
      end else if (bus.new_work) begin
         pend_mid_d  = bus.work_midstate;
         pend_data_d = bus.work_data;
         pending_d   = 1'b1;
      end else begin
         pending_d = pending_q;
      end

      // Golden flags seen right after a swap were produced by the previous work.
      if (check_s) begin
         if (suppress_q) begin
            suppress_d = 1'b0;
         end else if (|bus.gnon) begin
            push_s      = 1'b1;
            push_word_s = nonce_q - 32'(CORES) + lowest_set(bus.gnon);
         end else begin
            push_s = 1'b0;
         end
      end else if (marker_slot_s && marker_q) begin
         push_s      = 1'b1;
         push_word_s = 32'h0000_0000;
         marker_d    = 1'b0;
      end else begin
         push_s = 1'b0;
      end

      wr_ok_s = push_s && (!full_s || pop_s);
      if (push_s && !wr_ok_s) begin
         overflow_d = 1'b1;
      end else begin
         overflow_d = overflow_d;
      end
      if (wr_ok_s) begin
         fifo_mem_d[wr_ptr_q] = push_word_s;
         wr_ptr_d             = wr_ptr_q + PTR_ONE_C;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE_C;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({wr_ok_s, pop_s})
         2'b10:   count_d = count_q + CNT_ONE_C;
         2'b01:   count_d = count_q - CNT_ONE_C;
         default: count_d = count_q;
      endcase
   end

   // Sequencer, work, flag and FIFO registers.
   always_ff @(posedge hash_clk or posedge reset) begin
      if (reset) begin
         cnt_q       <= 8'd0;
         pass_q      <= 1'b0;
         nonce_q     <= 32'h0000_0000;
         midstate_q  <= 256'h0;
         data_q      <= 96'h0;
         pend_mid_q  <= 256'h0;
         pend_data_q <= 96'h0;
         pending_q   <= 1'b0;
         exhausted_q <= 1'b0;
         suppress_q  <= 1'b0;
         marker_q    <= 1'b0;
         overflow_q  <= 1'b0;
         fifo_mem_q  <= '{default: 32'h0000_0000};
         wr_ptr_q    <= {AW{1'b0}};
         rd_ptr_q    <= {AW{1'b0}};
         count_q     <= CNT_ZERO_C;
      end else begin
         cnt_q       <= cnt_d;
         pass_q      <= pass_d;
         nonce_q     <= nonce_d;
         midstate_q  <= midstate_d;
         data_q      <= data_d;
         pend_mid_q  <= pend_mid_d;
         pend_data_q <= pend_data_d;
         pending_q   <= pending_d;
         exhausted_q <= exhausted_d;
         suppress_q  <= suppress_d;
         marker_q    <= marker_d;
         overflow_q  <= overflow_d;
         fifo_mem_q  <= fifo_mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

   // Transmit FSM; GUARD covers the transmitter's delay before it raises busy.
   always_ff @(posedge hash_clk or posedge reset) begin
      if (reset) begin
         tx_state_q <= TX_IDLE;
         tx_send_q  <= 1'b0;
         tx_word_q  <= 32'h0000_0000;
      end else begin
         case (tx_state_q)
            TX_IDLE: begin
               if (pop_s) begin
                  tx_state_q <= TX_SEND;
                  tx_send_q  <= 1'b1;
                  tx_word_q  <= fifo_mem_q[rd_ptr_q];
               end else begin
                  tx_send_q <= 1'b0;
               end
            end
            TX_SEND: begin
               tx_state_q <= TX_GUARD;
               tx_send_q  <= 1'b0;
            end
            TX_GUARD: begin
               if (!bus.tx_busy) begin
                  tx_state_q <= TX_IDLE;
               end else begin
                  tx_state_q <= TX_GUARD;
               end
               tx_send_q <= 1'b0;
            end
            default: begin
               tx_state_q <= TX_IDLE;
               tx_send_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.cnt           = cnt_q;
   assign bus.pass          = pass_q;
   assign bus.nonce         = nonce_q;
   assign bus.midstate      = midstate_q;
   assign bus.data          = data_q;
   assign bus.tx_send       = tx_send_q;
   assign bus.tx_word       = tx_word_q;
   assign bus.fifo_overflow = overflow_q;

endmodule

// File: tb/tb_microcore_scheduler.sv
// Scoreboard bench for microcore_scheduler (CORES=4, FIFO_DEPTH=4, default round timing).
`timescale 1ns/1ps
module tb_microcore_scheduler;
   localparam int CORES = 4;
   localparam logic [255:0] MID_A  = {8{32'hA5A5_A5A5}};
   localparam logic [95:0]  DATA_A = 96'h0123_4567_89AB_CDEF_0011_2233;
   localparam logic [255:0] MID_B  = {8{32'h3C3C_0F0F}};
   localparam logic [95:0]  DATA_B = 96'hFEDC_BA98_7654_3210_4455_6677;

   logic hash_clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail = 0;
   int   sends_seen = 0;
   int   cyc = 0;
   int   last_send_cyc = -100;
   int   snap;
   logic [31:0] exp_q [$];
   logic [3:0]  ovf_pat  [5] = '{4'b0010, 4'b0100, 4'b1100, 4'b1111, 4'b0001};
   logic [31:0] ovf_word [5] = '{32'd1, 32'd6, 32'd10, 32'd12, 32'd16};

   always #5 hash_clk = ~hash_clk;

   microcore_scheduler_if #(.CORES(CORES)) bus ();

   microcore_scheduler #(
      .CORES(CORES), .FIFO_DEPTH(4), .P0_LAST(66), .P1_LAST(61), .CHECK_CNT(1)
   ) dut (
      .hash_clk(hash_clk),
      .reset   (reset),
      .bus     (bus)
   );

`ifdef NONCE_RANGE_EN
   initial begin
      bus.work_nonce_start = 32'h0000_0000;
      bus.work_nonce_end   = 32'hFFFF_FFFF;
   end
`endif

   always @(posedge hash_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge hash_clk);
   endtask

   task automatic wait_state(input logic p, input logic [7:0] c);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 300 && !hit; i++) begin
         @(negedge hash_clk);
         if (bus.pass === p && bus.cnt === c) hit = 1'b1;
      end
      if (!hit) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_state: pass %0d cnt %0d not reached within 300 cycles", p, c);
      end
   endtask

   // Scoreboard monitor: each tx_send pulse is matched to the oldest expected word.
   always @(negedge hash_clk) begin
      if (reset === 1'b0 && bus.tx_send === 1'b1) begin
         sends_seen = sends_seen + 1;
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_send: got tx_word %0h, required no send", bus.tx_word);
         end else begin
            check("tx_word", bus.tx_word, exp_q.pop_front());
         end
         if (last_send_cyc >= 0) begin
            n_tests++;
            if (cyc - last_send_cyc < 3) begin
               n_fail++;
               $display("FAIL send_spacing: got %0d cycles, required >= 3", cyc - last_send_cyc);
            end
         end
         last_send_cyc = cyc;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      reset = 1'b1;
      bus.new_work = 1'b0;
      bus.work_midstate = 256'h0;
      bus.work_data = 96'h0;
      bus.gnon = 4'b0000;
      bus.tx_busy = 1'b0;
      #1;
      check("rst_cnt", bus.cnt, 8'd0);
      check("rst_pass", bus.pass, 1'b0);
      check("rst_nonce", bus.nonce, 32'h0);
      check("rst_midstate", bus.midstate, 256'h0);
      check("rst_data", bus.data, 96'h0);
      check("rst_tx_send", bus.tx_send, 1'b0);
      check("rst_tx_word", bus.tx_word, 32'h0);
      check("rst_overflow", bus.fifo_overflow, 1'b0);
      repeat (3) tick();
      reset = 1'b0;

      // Free-running rounds
      repeat (67) tick();
      check("pass1_start_pass", bus.pass, 1'b1);
      check("pass1_start_cnt", bus.cnt, 8'd0);
      repeat (61) tick();
      check("pass1_last_cnt", bus.cnt, 8'd61);
      check("pass1_last_nonce", bus.nonce, 32'd0);
      tick();
      check("round1_nonce", bus.nonce, 32'd4);
      check("round1_pass", bus.pass, 1'b0);
      check("round1_cnt", bus.cnt, 8'd0);
      repeat (129) tick();
      check("round2_nonce", bus.nonce, 32'd8);

      // Golden hit at nonce 8: lowest set core 1 -> 8 - 4 + 1
      tick();
      check("check_cnt", bus.cnt, 8'd1);
      bus.gnon = 4'b0110;
      exp_q.push_back(32'd5);
      tick();
      bus.gnon = 4'b0000;
      check("golden_lat1", bus.tx_send, 1'b0);
      tick();
      check("golden_lat2", bus.tx_send, 1'b1);

      // Work swap in mid pass 0
      repeat (10) tick();
      bus.new_work = 1'b1;
      bus.work_midstate = MID_A;
      bus.work_data = DATA_A;
      tick();
      bus.new_work = 1'b0;
      check("swap_not_early", bus.midstate, 256'h0);
      wait_state(1'b1, 8'd61);
      check("swap_hold_mid", bus.midstate, 256'h0);
      check("swap_hold_nonce", bus.nonce, 32'd8);
      tick();
      check("swap_mid", bus.midstate, MID_A);
      check("swap_data", bus.data, DATA_A);
      check("swap_nonce", bus.nonce, 32'd0);
      tick();
      bus.gnon = 4'b0001;
      tick();
      bus.gnon = 4'b0000;
      snap = sends_seen;
      repeat (5) tick();
      check("suppress_no_send", sends_seen, snap);
      wait_state(1'b0, 8'd0);
      check("after_swap_nonce", bus.nonce, 32'd4);
      tick();
      bus.gnon = 4'b1000;
      exp_q.push_back(32'd3);
      tick();
      bus.gnon = 4'b0000;
      repeat (4) tick();

      // Exhaustion: nonce forced to the top of the range
      wait_state(1'b1, 8'd10);
      force dut.nonce_q = 32'hFFFF_FFFF;
      tick();
      release dut.nonce_q;
      exp_q.push_back(32'h0);
      snap = sends_seen;
      wait_state(1'b0, 8'd0);
      check("exhaust_wrap", bus.nonce, 32'd0);
      repeat (6) tick();
      check("marker_sent", sends_seen, snap + 1);
      wait_state(1'b1, 8'd10);
      force dut.nonce_q = 32'hFFFF_FFFF;
      tick();
      release dut.nonce_q;
      snap = sends_seen;
      wait_state(1'b0, 8'd0);
      check("exhaust_wrap2", bus.nonce, 32'd0);
      repeat (8) tick();
      check("single_marker", sends_seen, snap);

      // Backpressure and overflow: five hits with the transmitter busy
      bus.tx_busy = 1'b1;
      snap = sends_seen;
      for (int r = 0; r < 5; r++) begin
         wait_state(1'b0, 8'd1);
         check("ovf_nonce", bus.nonce, 32'(4 + 4 * r));
         if (r == 4) check("ovf_before", bus.fifo_overflow, 1'b0);
         bus.gnon = ovf_pat[r];
         if (r < 4) exp_q.push_back(ovf_word[r]);
         tick();
         bus.gnon = 4'b0000;
      end
      check("ovf_set", bus.fifo_overflow, 1'b1);
      check("ovf_no_send_busy", sends_seen, snap);
      bus.tx_busy = 1'b0;
      repeat (20) tick();
      check("drain_count", sends_seen, snap + 4);
      check("ovf_sticky", bus.fifo_overflow, 1'b1);

      // new_work on the boundary cycle applies directly and clears overflow
      wait_state(1'b1, 8'd61);
      bus.new_work = 1'b1;
      bus.work_midstate = MID_B;
      bus.work_data = DATA_B;
      tick();
      bus.new_work = 1'b0;
      check("direct_mid", bus.midstate, MID_B);
      check("direct_data", bus.data, DATA_B);
      check("direct_nonce", bus.nonce, 32'd0);
      check("ovf_cleared", bus.fifo_overflow, 1'b0);
      wait_state(1'b0, 8'd0);
      check("no_pending_left", bus.nonce, 32'd4);

      // Async reset during a SEND with a second word still queued
      bus.tx_busy = 1'b1;
      wait_state(1'b0, 8'd1);
      bus.gnon = 4'b0100;
      exp_q.push_back(32'd2);
      tick();
      bus.gnon = 4'b0000;
      wait_state(1'b0, 8'd1);
      bus.gnon = 4'b0010;
      tick();
      bus.gnon = 4'b0000;
      bus.tx_busy = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick();
         if (bus.tx_send === 1'b1) seen = 1'b1;
      end
      check("send_before_reset", seen, 1'b1);
      #1;
      reset = 1'b1;
      #1;
      check("arst_tx_send", bus.tx_send, 1'b0);
      check("arst_cnt", bus.cnt, 8'd0);
      check("arst_nonce", bus.nonce, 32'd0);
      check("arst_mid", bus.midstate, 256'h0);
      repeat (2) tick();
      reset = 1'b0;
      snap = sends_seen;
      repeat (129) tick();
      check("post_reset_nonce", bus.nonce, 32'd4);
      repeat (20) tick();
      check("no_send_after_reset", sends_seen, snap);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/microcore_scheduler.md
# microcore_scheduler

Parametrised round sequencer and result collector for an array of `CORES` microcore hashers. It generates the shared `cnt`/`pass` schedule, holds the active midstate/data, and steps the nonce by `CORES` per round. It double-buffers incoming work and swaps it only at round boundaries. Golden-nonce hits and exhaustion markers are queued in a small FIFO and drained to the serial transmitter through its send/busy handshake.

## Interface
Parameters:
- `CORES`, 1: number of microcores; core j hashes `nonce + j`.
- `FIFO_DEPTH`, 4: result FIFO entries, power of two, ≥2.
- `P0_LAST`, 66: final `cnt` value of pass 0.
- `P1_LAST`, 61: final `cnt` value of pass 1.
- `CHECK_CNT`, 1: pass-0 `cnt` value at which `gnon` is sampled; must be < `P0_LAST`.

Ports:
- `hash_clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-high.
- `new_work` in 1: one-cycle strobe; latch `work_midstate`/`work_data` into the pending buffer.
- `work_midstate` in 256: next midstate.
- `work_data` in 96: next header tail.
- `gnon` in CORES: per-core golden flags.
- `tx_busy` in 1: serial transmitter busy.
- `cnt` out 8: round step counter to the cores.
- `pass` out 1: 0 = first SHA pass, 1 = second SHA pass.
- `midstate` out 256: active midstate.
- `data` out 96: active data.
- `nonce` out 32: base nonce of the current round.
- `tx_send` out 1: one-cycle send strobe.
- `tx_word` out 32: word to transmit; stable from `tx_send` until the next send.
- `fifo_overflow` out 1: sticky; a result was dropped.

## Operation
- Reset values: `cnt`=0, `pass`=0, `nonce`=0, `midstate`=0, `data`=0, `tx_send`=0, `tx_word`=0, `fifo_overflow`=0. FIFO empty, pending flag clear, exhausted flag clear, suppress flag clear, TX state IDLE.
- Round sequencing:
  - Pass 0: `cnt` counts 0..`P0_LAST`. It then returns to 0 and `pass` becomes 1.
  - Pass 1: `cnt` counts 0..`P1_LAST`. It then returns to 0 and `pass` becomes 0. This cycle is the **boundary**.
- Nonce at the boundary:
  - Pending work: `midstate`/`data` load from the buffer, `nonce` loads the start value (0), pending clears, exhausted clears, suppress sets.
  - No pending work: `nonce` becomes `nonce + CORES`, modulo 2^32.
- Exhaustion: at a boundary without pending work, if `nonce + CORES` carries out of 32 bits (or passes the end limit, see Configuration), set the exhausted flag and arm a marker. Only one marker is armed per work unit. The nonce wraps to the start value and searching continues.
- `new_work`: overwrites the buffer and sets pending; the last strobe before a boundary wins. If `new_work` coincides with a boundary, the strobed value is applied directly at that boundary and pending stays clear.
- Check cycle (`pass`=0, `cnt`=`CHECK_CNT`):
  - If suppress is set: ignore `gnon` and clear suppress, because the flags belong to the previous work.
  - Else, if any `gnon` bit is set: push `nonce - CORES + j` modulo 2^32, where j is the lowest set index. Only one push per round.
  - An armed marker pushes 32'h00000000 on the check cycle + 1, so a golden push and a marker in the same round are both kept, golden first.
- FIFO full: a push attempted when the FIFO is full is dropped and sets `fifo_overflow`. `fifo_overflow` clears only on reset or on a work swap.
- TX state machine:
  - IDLE → SEND when the FIFO is non-empty and `tx_busy`=0. In the SEND cycle, `tx_send`=1, `tx_word` = FIFO head, and the head is popped.
  - SEND → GUARD for one cycle, covering the transmitter's busy latency.
  - GUARD → IDLE when `tx_busy`=0.
- Simultaneous push and pop are allowed. Occupancy is then unchanged, including at full.

## Timing
- `cnt`, `pass`, `nonce`, `midstate`, `data`: registered outputs, all updating on the same `hash_clk` edge.
- Round length: `P0_LAST + P1_LAST + 2` cycles (129 at defaults).
- Golden latency: from a `gnon` sample at the check cycle to `tx_send` is 2 cycles minimum (push, then SEND), with the FIFO empty and `tx_busy`=0.
- Minimum spacing between `tx_send` pulses: 3 cycles.
- Reset asserted mid-round: all state clears immediately (asynchronous). On deassertion, sequencing resumes at `pass`=0, `cnt`=0 on the next edge.

## Configuration
- `NONCE_RANGE_EN` defined:
  - Adds inputs `work_nonce_start` and `work_nonce_end` (32 bits each), latched together with the work.
  - The nonce loads `start` on swap and on wrap.
  - Exhaustion triggers when `nonce + CORES` > `end` or carries out.
- `NONCE_RANGE_EN` undefined: start is 0, end is 32'hFFFFFFFF, and exhaustion triggers only on carry-out.

## Test plan
- Free-running round, CORES=4: after reset, round 1 ends after 129 cycles with `nonce`=4. Round 2 ends with `nonce`=8.
- Golden hit, CORES=4: at the check cycle with `nonce`=8, drive `gnon`=4'b0110 → FIFO receives 5, and `tx_send` pulses 2 cycles later with `tx_word`=5.
- Work swap: strobe `new_work` mid-pass-0 with midstate=256'hA5… → outputs change only at the boundary, `nonce`=0. At the next check, `gnon`=1 is ignored.
- Exhaustion, CORES=1: force `nonce` to 32'hFFFFFFFF (no pending work) → at the boundary `nonce` becomes 0, and one 32'h0 marker is sent. No second marker is sent on the later wrap.
- Backpressure and overflow, FIFO_DEPTH=4: hold `tx_busy`=1 and inject a hit in 5 consecutive rounds → 4 words are queued, `fifo_overflow`=1. Releasing `tx_busy` drains the 4 words in order with ≥3-cycle spacing.
- Async reset mid-SEND: assert `reset` during `tx_send` → `tx_send`=0 and the FIFO is empty the same cycle; no further sends occur.
